// File: rtl/switch_perf_monitor.sv
// switch_perf_monitor: per-channel performance counters for switch input
// buffers. Each channel tracks packets framed by not_idle and accumulates
// packet count, latency sum/max, active-cycle sum and flit sum. All values
// are read through a registered port with one cycle of latency.
//
// Ports
//   clk, nrst                  clock, async active-low reset
//   not_idle/is_active/
//   flit_sent [NUM_CH]         per-channel event strobes
//   clear                      sync clear of all stats, all channels
//   rd_en, rd_chan, rd_sel     read request
//   rd_data, rd_valid          read response, one cycle after rd_en
//
// rd_sel: 0 pkt_cnt, 1 lat_sum, 2 lat_max, 3 active_sum, 4 flit_sum,
//         5 status {sat[4:0], state[1:0]}, 6-7 zero.

// Per-channel state machine plus accumulators.
module switch_perf_chan #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             not_idle,
  input  logic             is_active,
  input  logic             flit_sent,
  input  logic             clear,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] lat_sum,
  output logic [LAT_W-1:0] lat_max,
  output logic [CNT_W-1:0] active_sum,
  output logic [CNT_W-1:0] flit_sum,
  output logic [4:0]       sat,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DROP = 2'd2} st_e;

  st_e              st, st_nx;
  logic [LAT_W-1:0] cur_lat, cur_act, cur_flit;
  logic [LAT_W-1:0] cur_lat_nx, cur_act_nx, cur_flit_nx, lat_max_nx;
  logic [CNT_W-1:0] pkt_nx, lsum_nx, asum_nx, fsum_nx;
  logic [4:0]       sat_nx;
  // MSB of each sum is the "clamped" flag, low bits the saturated value
  logic [LAT_W:0]   lat_c, act_c, flit_c;
  logic [CNT_W:0]   pkt_c, lsum_c, asum_c, fsum_c;

  function automatic logic [LAT_W:0] sat_inc(input logic [LAT_W-1:0] a, input logic b);
    logic [LAT_W:0] s;
    s = {1'b0, a} + (LAT_W+1)'(b);
    return s[LAT_W] ? {1'b1, {LAT_W{1'b1}}} : s;
  endfunction

  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : s;
  endfunction

  assign state = st;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) st <= IDLE;
    else       st <= st_nx;

  // clear parks any packet already under way in DROP so it is never counted
  always_comb begin
    st_nx = st;
    if (clear) st_nx = (st == BUSY || (st == IDLE && not_idle)) ? DROP : IDLE;
    else case (st)
      IDLE:    if (not_idle)  st_nx = BUSY;
      BUSY:    if (!not_idle) st_nx = IDLE;
      DROP:    if (!not_idle) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_lat_nx  = cur_lat;
    cur_act_nx  = cur_act;
    cur_flit_nx = cur_flit;
    pkt_nx      = pkt_cnt;
    lsum_nx     = lat_sum;
    lat_max_nx  = lat_max;
    asum_nx     = active_sum;
    fsum_nx     = flit_sum;
    sat_nx      = sat;
    lat_c  = sat_inc(cur_lat, 1'b1);
    act_c  = sat_inc(cur_act, is_active);
    flit_c = sat_inc(cur_flit, flit_sent);
    pkt_c  = sat_add(pkt_cnt, CNT_W'(1));
    lsum_c = sat_add(lat_sum, CNT_W'(cur_lat));
    asum_c = sat_add(active_sum, CNT_W'(cur_act));
    fsum_c = sat_add(flit_sum, CNT_W'(cur_flit));
    if (clear) begin
      cur_lat_nx = '0; cur_act_nx = '0; cur_flit_nx = '0;
      pkt_nx = '0; lsum_nx = '0; lat_max_nx = '0; asum_nx = '0; fsum_nx = '0;
      sat_nx = '0;
    end else case (st)
      IDLE: if (not_idle) begin
        cur_lat_nx  = LAT_W'(1);
        cur_act_nx  = LAT_W'(is_active);
        cur_flit_nx = LAT_W'(flit_sent);
      end
      BUSY: if (not_idle) begin
        cur_lat_nx  = lat_c[LAT_W-1:0];
        cur_act_nx  = act_c[LAT_W-1:0];
        cur_flit_nx = flit_c[LAT_W-1:0];
        sat_nx[4]   = sat[4] | lat_c[LAT_W];
        sat_nx[2]   = sat[2] | act_c[LAT_W];
        sat_nx[3]   = sat[3] | flit_c[LAT_W];
      end else begin
        // commit; strobes on this cycle belong to no packet
        pkt_nx     = pkt_c[CNT_W-1:0];
        lsum_nx    = lsum_c[CNT_W-1:0];
        asum_nx    = asum_c[CNT_W-1:0];
        fsum_nx    = fsum_c[CNT_W-1:0];
        lat_max_nx = (cur_lat > lat_max) ? cur_lat : lat_max;
        sat_nx[3:0] = sat[3:0] | {fsum_c[CNT_W], asum_c[CNT_W], lsum_c[CNT_W], pkt_c[CNT_W]};
        cur_lat_nx = '0; cur_act_nx = '0; cur_flit_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cur_lat <= '0; cur_act <= '0; cur_flit <= '0;
      pkt_cnt <= '0; lat_sum <= '0; lat_max <= '0; active_sum <= '0; flit_sum <= '0;
      sat <= '0;
    end else begin
      cur_lat <= cur_lat_nx; cur_act <= cur_act_nx; cur_flit <= cur_flit_nx;
      pkt_cnt <= pkt_nx; lat_sum <= lsum_nx; lat_max <= lat_max_nx;
      active_sum <= asum_nx; flit_sum <= fsum_nx;
      sat <= sat_nx;
    end
endmodule

module switch_perf_monitor #(
  parameter  int NUM_CH = 8,
  parameter  int CNT_W  = 32,
  parameter  int LAT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_CH-1:0] not_idle,
  input  logic [NUM_CH-1:0] is_active,
  input  logic [NUM_CH-1:0] flit_sent,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_chan,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid
);
  logic [NUM_CH-1:0][CNT_W-1:0] pkt_cnt, lat_sum, active_sum, flit_sum;
  logic [NUM_CH-1:0][LAT_W-1:0] lat_max;
  logic [NUM_CH-1:0][4:0]       sat;
  logic [NUM_CH-1:0][1:0]       state;
  logic [CNT_W-1:0]             rd_mux;
  logic [CH_W-1:0]              ch;
  logic                         ch_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    switch_perf_chan #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_ch (
      .clk(clk), .nrst(nrst),
      .not_idle(not_idle[g]), .is_active(is_active[g]), .flit_sent(flit_sent[g]),
      .clear(clear),
      .pkt_cnt(pkt_cnt[g]), .lat_sum(lat_sum[g]), .lat_max(lat_max[g]),
      .active_sum(active_sum[g]), .flit_sum(flit_sum[g]),
      .sat(sat[g]), .state(state[g])
    );
  end

  // out-of-range channels read as zero but still produce rd_valid
  assign ch_ok = 32'(rd_chan) < NUM_CH;
  assign ch    = ch_ok ? rd_chan : '0;

  always_comb begin
    rd_mux = '0;
    if (ch_ok) case (rd_sel)
      3'd0:    rd_mux = pkt_cnt[ch];
      3'd1:    rd_mux = lat_sum[ch];
      3'd2:    rd_mux = CNT_W'(lat_max[ch]);
      3'd3:    rd_mux = active_sum[ch];
      3'd4:    rd_mux = flit_sum[ch];
      3'd5:    rd_mux = CNT_W'({sat[ch], state[ch]});
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_switch_perf_monitor.sv
// Randomised and directed bench for switch_perf_monitor against a
// packet-level reference model of the counter rules.
module tb_switch_perf_monitor;
  localparam int NUM_CH = 6;
  localparam int CNT_W  = 10;
  localparam int LAT_W  = 4;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;
  localparam longint LMAX = (longint'(1) << LAT_W) - 1;

  logic clk = 1'b0;
  logic nrst;
  logic [NUM_CH-1:0] not_idle, is_active, flit_sent;
  logic clear, rd_en, rd_valid;
  logic [2:0] rd_chan, rd_sel;
  logic [CNT_W-1:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  switch_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .nrst(nrst), .not_idle(not_idle), .is_active(is_active),
    .flit_sent(flit_sent), .clear(clear), .rd_en(rd_en), .rd_chan(rd_chan),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // reference model: mode 0 idle, 1 in packet, 2 discarding a cleared packet
  int     m_mode[NUM_CH];
  longint m_cl[NUM_CH], m_ca[NUM_CH], m_cf[NUM_CH];
  longint m_pkt[NUM_CH], m_lsum[NUM_CH], m_lmax[NUM_CH], m_asum[NUM_CH], m_fsum[NUM_CH];
  int     m_sat[NUM_CH];
  logic [CNT_W-1:0] m_rd;
  logic   m_rv;

  function automatic longint clamp_add(input longint a, input longint b, input longint mx,
                                       input int c, input int flag);
    if (a + b > mx) begin m_sat[c] |= (1 << flag); return mx; end
    return a + b;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0; m_cl[c] = 0; m_ca[c] = 0; m_cf[c] = 0;
      m_pkt[c] = 0; m_lsum[c] = 0; m_lmax[c] = 0; m_asum[c] = 0; m_fsum[c] = 0;
      m_sat[c] = 0;
    end
    m_rd = '0; m_rv = 1'b0;
  endfunction

  function automatic logic [CNT_W-1:0] model_read(input int c, input int s);
    longint v;
    v = 0;
    if (c < NUM_CH) case (s)
      0: v = m_pkt[c];
      1: v = m_lsum[c];
      2: v = m_lmax[c];
      3: v = m_asum[c];
      4: v = m_fsum[c];
      5: v = m_sat[c] * 4 + m_mode[c];
      default: v = 0;
    endcase
    return CNT_W'(v);
  endfunction

  function automatic void model_step();
    if (rd_en) begin m_rv = 1'b1; m_rd = model_read(int'(rd_chan), int'(rd_sel)); end
    else m_rv = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit ni, a, f;
      ni = not_idle[c]; a = is_active[c]; f = flit_sent[c];
      if (clear) begin
        m_mode[c] = (m_mode[c] == 1 || (m_mode[c] == 0 && ni)) ? 2 : 0;
        m_cl[c] = 0; m_ca[c] = 0; m_cf[c] = 0;
        m_pkt[c] = 0; m_lsum[c] = 0; m_lmax[c] = 0; m_asum[c] = 0; m_fsum[c] = 0;
        m_sat[c] = 0;
      end else if (m_mode[c] == 0) begin
        if (ni) begin m_mode[c] = 1; m_cl[c] = 1; m_ca[c] = a; m_cf[c] = f; end
      end else if (m_mode[c] == 1) begin
        if (ni) begin
          m_cl[c] = clamp_add(m_cl[c], 1, LMAX, c, 4);
          m_ca[c] = clamp_add(m_ca[c], a, LMAX, c, 2);
          m_cf[c] = clamp_add(m_cf[c], f, LMAX, c, 3);
        end else begin
          m_pkt[c]  = clamp_add(m_pkt[c], 1, CMAX, c, 0);
          m_lsum[c] = clamp_add(m_lsum[c], m_cl[c], CMAX, c, 1);
          m_asum[c] = clamp_add(m_asum[c], m_ca[c], CMAX, c, 2);
          m_fsum[c] = clamp_add(m_fsum[c], m_cf[c], CMAX, c, 3);
          if (m_cl[c] > m_lmax[c]) m_lmax[c] = m_cl[c];
          m_mode[c] = 0;
        end
      end else if (!ni) m_mode[c] = 0;
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int c, input int s, output logic [CNT_W-1:0] d, output logic v);
    rd_en = 1'b1; rd_chan = 3'(c); rd_sel = 3'(s);
    cyc();
    d = rd_data; v = rd_valid;
    rd_en = 1'b0;
  endtask

  // len cycles of not_idle on channel c, then the single low commit cycle
  task automatic pkt(input int c, input int len, input int act, input int flt);
    for (int i = 0; i < len; i++) begin
      not_idle[c] = 1'b1; is_active[c] = act[i]; flit_sent[c] = flt[i];
      cyc();
    end
    not_idle[c] = 1'b0; is_active[c] = 1'b0; flit_sent[c] = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] d; logic v;
    nrst = 1'b0; not_idle = '0; is_active = '0; flit_sent = '0;
    clear = 1'b0; rd_en = 1'b0; rd_chan = '0; rd_sel = '0;
    model_reset();
    #3;
    n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_err++; $display("FAIL reset_out: rd_valid=%b rd_data=%0d, want 0/0", rd_valid, rd_data);
    end
    @(posedge clk); #1; nrst = 1'b1;
    for (int s = 0; s < 6; s++) begin
      rd(0, s, d, v); n_vec++;
      if (v !== 1'b1 || d !== '0) begin
        n_err++; $display("FAIL reset_reg sel%0d: got %0d valid %b, want 0 valid 1", s, d, v);
      end
    end
  endtask

  task automatic test_basic();
    logic [CNT_W-1:0] d; logic v;
    logic [CNT_W-1:0] exp [5];
    exp = '{10'd1, 10'd5, 10'd5, 10'd3, 10'd2};
    pkt(0, 5, 5'b00111, 5'b00101);
    for (int s = 0; s < 5; s++) begin
      rd(0, s, d, v); n_vec++;
      if (v !== 1'b1 || d !== exp[s]) begin
        n_err++; $display("FAIL basic sel%0d: got %0d, want %0d", s, d, exp[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] d; logic v;
    cyc();
    pkt(0, 3, 0, 0);
    rd(0, 0, d, v); n_vec++;
    if (d !== 10'd2) begin n_err++; $display("FAIL second_pkt_cnt: got %0d, want 2", d); end
    rd(0, 1, d, v); n_vec++;
    if (d !== 10'd8) begin n_err++; $display("FAIL second_lat_sum: got %0d, want 8", d); end
    rd(0, 2, d, v); n_vec++;
    if (d !== 10'd5) begin n_err++; $display("FAIL second_lat_max: got %0d, want 5", d); end
    for (int s = 0; s < 6; s++) begin
      rd(1, s, d, v); n_vec++;
      if (d !== '0) begin n_err++; $display("FAIL ch1_quiet sel%0d: got %0d, want 0", s, d); end
    end
    // one-cycle gap between two packets on ch2
    pkt(2, 2, 0, 0);
    pkt(2, 3, 0, 0);
    rd(2, 0, d, v); n_vec++;
    if (d !== 10'd2) begin n_err++; $display("FAIL gap_pkt_cnt: got %0d, want 2", d); end
    rd(2, 1, d, v); n_vec++;
    if (d !== 10'd5) begin n_err++; $display("FAIL gap_lat_sum: got %0d, want 5", d); end
    rd(2, 2, d, v); n_vec++;
    if (d !== 10'd3) begin n_err++; $display("FAIL gap_lat_max: got %0d, want 3", d); end
  endtask

  task automatic test_clear();
    logic [CNT_W-1:0] d; logic v;
    not_idle[3] = 1'b1; cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    rd(3, 5, d, v); n_vec++;
    if (d !== 10'd2) begin n_err++; $display("FAIL clear_drop_state: got %0d, want 2", d); end
    cyc(); cyc(); cyc();
    not_idle[3] = 1'b0; cyc();
    rd(3, 0, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL clear_pkt_cnt: got %0d, want 0", d); end
    rd(3, 1, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL clear_lat_sum: got %0d, want 0", d); end
    rd(3, 5, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL clear_idle_state: got %0d, want 0", d); end
    rd(0, 0, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL clear_ch0: got %0d, want 0", d); end
    pkt(3, 4, 0, 0);
    rd(3, 0, d, v); n_vec++;
    if (d !== 10'd1) begin n_err++; $display("FAIL after_clear_pkt: got %0d, want 1", d); end
    rd(3, 1, d, v); n_vec++;
    if (d !== 10'd4) begin n_err++; $display("FAIL after_clear_lat: got %0d, want 4", d); end
  endtask

  task automatic test_lat_sat();
    logic [CNT_W-1:0] d; logic v;
    pkt(4, 20, 0, 0);
    rd(4, 1, d, v); n_vec++;
    if (d !== 10'd15) begin n_err++; $display("FAIL sat_lat_sum: got %0d, want 15", d); end
    rd(4, 2, d, v); n_vec++;
    if (d !== 10'd15) begin n_err++; $display("FAIL sat_lat_max: got %0d, want 15", d); end
    rd(4, 5, d, v); n_vec++;
    if (d !== 10'd64) begin n_err++; $display("FAIL sat_flag: got %0d, want 64", d); end
    pkt(4, 2, 0, 0);
    rd(4, 5, d, v); n_vec++;
    if (d !== 10'd64) begin n_err++; $display("FAIL sat_sticky: got %0d, want 64", d); end
    rd(4, 1, d, v); n_vec++;
    if (d !== 10'd17) begin n_err++; $display("FAIL sat_lat_sum2: got %0d, want 17", d); end
    clear = 1'b1; cyc(); clear = 1'b0;
    rd(4, 5, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL sat_cleared: got %0d, want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [CNT_W-1:0] d; logic v;
    not_idle = '1; cyc(); cyc(); cyc();
    rd(0, 5, d, v); n_vec++;
    if (d !== 10'd1) begin n_err++; $display("FAIL busy_state: got %0d, want 1", d); end
    #2; nrst = 1'b0; model_reset();
    #1; n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_err++; $display("FAIL mid_reset_out: rd_valid=%b rd_data=%0d, want 0/0", rd_valid, rd_data);
    end
    @(posedge clk); #1;
    not_idle = '0; nrst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      rd(c, 5, d, v); n_vec++;
      if (d !== '0) begin n_err++; $display("FAIL mid_reset_state ch%0d: got %0d, want 0", c, d); end
    end
    rd(5, 0, d, v); n_vec++;
    if (d !== '0) begin n_err++; $display("FAIL mid_reset_pkt: got %0d, want 0", d); end
    pkt(5, 2, 0, 0);
    rd(5, 0, d, v); n_vec++;
    if (d !== 10'd1) begin n_err++; $display("FAIL post_reset_pkt: got %0d, want 1", d); end
    rd(5, 1, d, v); n_vec++;
    if (d !== 10'd2) begin n_err++; $display("FAIL post_reset_lat: got %0d, want 2", d); end
  endtask

  task automatic test_read_corners();
    logic [CNT_W-1:0] d; logic v;
    pkt(0, 1, 0, 0);
    not_idle[0] = 1'b1; cyc(); cyc();
    not_idle[0] = 1'b0;
    rd(0, 0, d, v); n_vec++;
    if (d !== 10'd1) begin n_err++; $display("FAIL read_at_commit: got %0d, want 1", d); end
    rd(0, 0, d, v); n_vec++;
    if (d !== 10'd2) begin n_err++; $display("FAIL read_after_commit: got %0d, want 2", d); end
    rd(NUM_CH, 0, d, v); n_vec++;
    if (v !== 1'b1 || d !== '0) begin
      n_err++; $display("FAIL bad_chan: got %0d valid %b, want 0 valid 1", d, v);
    end
    rd(0, 0, d, v);
    rd(0, 7, d, v); n_vec++;
    if (v !== 1'b1 || d !== '0) begin n_err++; $display("FAIL sel7: got %0d, want 0", d); end
    rd(0, 1, d, v);
    cyc(); n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== 10'd3) begin
      n_err++; $display("FAIL no_read_hold: valid %b data %0d, want 0/3", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    int rem[NUM_CH];
    logic [CNT_W-1:0] d; logic v;
    foreach (rem[c]) rem[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rem[c] > 0) begin
          not_idle[c] = 1'b1; rem[c]--;
        end else begin
          // always leave a low cycle between bursts so packets stay <= 12
          not_idle[c] = 1'b0;
          if ($urandom_range(0, 2) == 0) rem[c] = $urandom_range(1, 12);
        end
        is_active[c] = $urandom_range(0, 1);
        flit_sent[c] = $urandom_range(0, 1);
      end
      clear   = ($urandom_range(0, 1499) == 0);
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_chan = 3'($urandom_range(0, 7));
      rd_sel  = 3'($urandom_range(0, 7));
      cyc();
      n_vec++;
      if (rd_valid !== m_rv || rd_data !== m_rd) begin
        n_err++;
        $display("FAIL random t=%0d: valid %b data %0d, want %b %0d", t, rd_valid, rd_data, m_rv, m_rd);
      end
    end
    not_idle = '0; is_active = '0; flit_sent = '0; clear = 1'b0; rd_en = 1'b0;
    cyc();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 6; s++) begin
        rd(c, s, d, v); n_vec++;
        if (d !== m_rd) begin
          n_err++; $display("FAIL final ch%0d sel%0d: got %0d, want %0d", c, s, d, m_rd);
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clear();
    test_lat_sat();
    test_reset_mid();
    test_read_corners();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
